// File: rtl/writeback_if.sv
// writeback_if: MEM-to-WB handshake, load response and register-file write port
interface writeback_if;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic        in_reg_write;
    logic [1:0]  in_result_src;
    logic [31:0] in_alu_result;
    logic [31:0] in_pc_plus4;
    logic [31:0] in_imm;
    logic [2:0]  in_funct3;
    logic        flush;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        misalign_err;
    logic [31:0] retired_count;
    modport master (
        output in_valid, in_rd, in_reg_write, in_result_src, in_alu_result, in_pc_plus4,
               in_imm, in_funct3, flush, mem_rsp_valid, mem_rsp_data,
        input  in_ready, rf_wen, rf_waddr, rf_wdata, misalign_err, retired_count
    );
    modport slave (
        input  in_valid, in_rd, in_reg_write, in_result_src, in_alu_result, in_pc_plus4,
               in_imm, in_funct3, flush, mem_rsp_valid, mem_rsp_data,
        output in_ready, rf_wen, rf_waddr, rf_wdata, misalign_err, retired_count
    );
endinterface

// File: rtl/writeback_stage.sv
// writeback_stage: selects the result, extends loads, writes the register file and counts retirements
module writeback_stage (
    input logic         clk,
    input logic         rst,
    writeback_if.slave  wb
);
    typedef enum logic [1:0] {IDLE, WAIT_MEM, WRITE} state_t;
    state_t      state, state_nx;
    logic [4:0]  rd_q;
    logic        reg_write_q;
    logic [1:0]  src_q;
    logic [31:0] alu_q, pc4_q, imm_q, load_q, count_q;
    logic [2:0]  f3_q;
    logic        accept, mis;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] ext;
    assign wb.in_ready = !rst && state != WAIT_MEM;
    assign accept = wb.in_valid && wb.in_ready && !wb.flush;
    // load extension from the raw word, plus misalignment of the captured load
    always_comb begin
        byte_sel = wb.mem_rsp_data[{alu_q[1:0], 3'b000} +: 8];
        half_sel = wb.mem_rsp_data[{alu_q[1], 4'b0000} +: 16];
        ext = f3_q == 3'b000 ? {{24{byte_sel[7]}}, byte_sel} :
              f3_q == 3'b100 ? {24'b0, byte_sel} :
              f3_q == 3'b001 ? {{16{half_sel[15]}}, half_sel} :
              f3_q == 3'b101 ? {16'b0, half_sel} : wb.mem_rsp_data;
        mis = src_q == 2'b01 && (f3_q == 3'b011 || f3_q == 3'b110 || f3_q == 3'b111 ||
              ((f3_q == 3'b001 || f3_q == 3'b101) && alu_q[0]) ||
              (f3_q == 3'b010 && alu_q[1:0] != 2'b00));
    end
    // next state: loads park in WAIT_MEM until the response, everything else writes next cycle
    always_comb begin
        state_nx = state == WAIT_MEM ? (wb.mem_rsp_valid ? WRITE : WAIT_MEM) :
                   accept ? (wb.in_result_src == 2'b01 ? WAIT_MEM : WRITE) : IDLE;
    end
    // write port and error pulse driven from captured state only
    always_comb begin
        wb.rf_wen        = state == WRITE && reg_write_q && rd_q != 5'd0 && !mis;
        wb.misalign_err  = state == WRITE && mis;
        wb.rf_waddr      = rd_q;
        wb.rf_wdata      = src_q == 2'b00 ? alu_q : src_q == 2'b01 ? load_q :
                           src_q == 2'b10 ? pc4_q : imm_q;
        wb.retired_count = count_q;
    end
    // state, captured fields and retirement counter (counted on entry to WRITE)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            rd_q        <= '0;
            reg_write_q <= 1'b0;
            src_q       <= '0;
            alu_q       <= '0;
            pc4_q       <= '0;
            imm_q       <= '0;
            f3_q        <= '0;
            load_q      <= '0;
            count_q     <= '0;
        end else begin
            if (accept) begin
                rd_q        <= wb.in_rd;
                reg_write_q <= wb.in_reg_write;
                src_q       <= wb.in_result_src;
                alu_q       <= wb.in_alu_result;
                pc4_q       <= wb.in_pc_plus4;
                imm_q       <= wb.in_imm;
                f3_q        <= wb.in_funct3;
            end
            if (state == WAIT_MEM && wb.mem_rsp_valid) load_q <= ext;
            if (state_nx == WRITE) count_q <= count_q + 32'd1;
            state <= state_nx;
        end
    end
endmodule
